// File: rtl/sys_bus_initiator_pkg.sv
// Shared types/constants for the sys bus initiator: FSM state encoding and default bus widths.
// No timing of its own; no backpressure.
package sys_bus_pkg;
  localparam int SYS_AW = 32;
  localparam int SYS_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRB = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_t;
endpackage

// File: rtl/sys_bus_initiator_if.sv
// Command/response handshake plus sys bus strobe signals; master = initiator view, slave = requester/target view.
// Wires only: zero latency, backpressure only via cmd_ready_o.
interface sys_bus_initiator_if
  import sys_bus_pkg::*;
#(
  parameter int AW = SYS_AW,
  parameter int DW = SYS_DW
);
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic            cmd_we_i;
  logic [AW-1:0]   cmd_addr_i;
  logic [DW-1:0]   cmd_wdata_i;
  logic [DW/8-1:0] cmd_sel_i;
  logic            rsp_valid_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic            rsp_err_o;
  logic            rsp_tmo_o;
  logic [AW-1:0]   sys_addr;
  logic [DW-1:0]   sys_wdata;
  logic [DW/8-1:0] sys_sel;
  logic            sys_wen;
  logic            sys_ren;
  logic [DW-1:0]   sys_rdata;
  logic            sys_err;
  logic            sys_ack;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_sel_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o,
    output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_sel_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o,
    input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/sys_bus_initiator.sv
// Single-outstanding sys bus initiator: accept -> 1-cycle strobe -> wait ack -> 1-cycle response (min 3 cycles, next accept at +4).
// Busy => cmd_ready_o low; response is never stalled. SYS_BUS_INITIATOR_TIMEOUT_EN adds a TMO-cycle ack timeout.
module sys_bus_initiator
  import sys_bus_pkg::*;
#(
  parameter int AW  = SYS_AW,
  parameter int DW  = SYS_DW,
  parameter int TMO = 255
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  sys_bus_initiator_if.master bus
);

  if (TMO < 1 || TMO > 65535 || AW < 1 || DW < 8 || (DW % 8) != 0) begin : g_cfg_err
    $error("sys_bus_initiator: illegal AW/DW/TMO");
  end

  state_t          state;
  state_t          state_nxt;
  logic            we_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic            acc;
  logic            tmo_hit;

  assign bus.cmd_ready_o = (state == IDLE) && rstn_i;
  assign acc             = bus.cmd_valid_i && bus.cmd_ready_o;
  assign bus.sys_wen     = (state == STRB) && we_q;
  assign bus.sys_ren     = (state == STRB) && !we_q;
  assign bus.rsp_valid_o = (state == RSP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;

`ifdef SYS_BUS_INITIATOR_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_q;

  // Counter holds the number of completed ack-less WAIT cycles; fire when this one makes TMO.
  assign tmo_hit       = (state == WAIT) && !bus.sys_ack && ((tmo_cnt + 16'd1) == 16'(TMO));
  assign bus.rsp_tmo_o = tmo_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tmo_cnt <= 16'd0;
      tmo_q   <= 1'b0;
    end else begin
      if (state == STRB) begin
        tmo_cnt <= 16'd0;
      end else if ((state == WAIT) && !bus.sys_ack) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if ((state == WAIT) && (bus.sys_ack || tmo_hit)) begin
        tmo_q <= tmo_hit;
      end
    end
  end
`else
  assign tmo_hit       = 1'b0;
  assign bus.rsp_tmo_o = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc) state_nxt = STRB;
      STRB:    state_nxt = WAIT;
      WAIT:    if (bus.sys_ack || tmo_hit) state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      bus.sys_addr  <= '0;
      bus.sys_wdata <= '0;
      bus.sys_sel   <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        we_q          <= bus.cmd_we_i;
        bus.sys_addr  <= bus.cmd_addr_i;
        bus.sys_wdata <= bus.cmd_wdata_i;
        bus.sys_sel   <= bus.cmd_sel_i;
      end
      // Ack has priority over a coincident timeout; writes report zero read data.
      if ((state == WAIT) && bus.sys_ack) begin
        rdata_q <= we_q ? '0 : bus.sys_rdata;
        err_q   <= bus.sys_err;
      end else if (tmo_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sys_bus_initiator.sv
// Scoreboard bench for sys_bus_initiator: driver queues expected strobes/responses, monitor pops and compares.
// A behavioural sys bus target with per-command ack delay/error/ack-in-strobe behaviour.
`timescale 1ns/1ps
module tb_sys_bus_initiator;
  import sys_bus_pkg::*;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int TB_TMO = 8;
`ifdef SYS_BUS_INITIATOR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          dly;
    bit          err;
    bit          strb_ack;
    bit          never;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } strb_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
  } rsp_exp_t;

  typedef struct {
    int dly;
    bit err;
    bit strb_ack;
    bit never;
  } beh_t;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  sys_bus_initiator_if #(.AW(AW), .DW(DW)) bus();

  sys_bus_initiator #(.AW(AW), .DW(DW), .TMO(TB_TMO)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  strb_exp_t   strb_q[$];
  rsp_exp_t    rsp_q[$];
  beh_t        beh_q[$];
  logic [31:0] mem[logic [31:0]];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          resp_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  function automatic vec_t mk(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] s, int dly,
                              bit err, bit sa, bit nv, logic [31:0] er, logic ee);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.sel = s; v.dly = dly;
    v.err = err; v.strb_ack = sa; v.never = nv; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // Monitor: strobe and response checks, plus hold checks on idle response outputs
  initial begin
    int          cyc;
    int          last_strb;
    logic [31:0] h_rdata;
    logic        h_err;
    logic        h_tmo;
    strb_exp_t   se;
    rsp_exp_t    re;
    cyc = 0; last_strb = -100; h_rdata = '0; h_err = 1'b0; h_tmo = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rstn_i) begin
        h_rdata = '0; h_err = 1'b0; h_tmo = 1'b0;
        continue;
      end
      chk("wen_ren_exclusive", 64'(bus.sys_wen & bus.sys_ren), 64'd0);
      if (bus.sys_wen || bus.sys_ren) begin
        if (strb_q.size() == 0) begin
          fail("unexpected_strobe");
        end else begin
          se = strb_q.pop_front();
          chk("strb_wen", 64'(bus.sys_wen), 64'(se.we));
          chk("strb_addr", 64'(bus.sys_addr), 64'(se.addr));
          chk("strb_sel", 64'(bus.sys_sel), 64'(se.sel));
          if (se.we) chk("strb_wdata", 64'(bus.sys_wdata), 64'(se.wdata));
          chk("strb_spacing_ge4", 64'(cyc - last_strb >= 4), 64'd1);
        end
        last_strb = cyc;
      end
      if (bus.rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          fail("unexpected_rsp_valid");
        end else begin
          re = rsp_q.pop_front();
          chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(re.rdata));
          chk("rsp_err", 64'(bus.rsp_err_o), 64'(re.err));
          chk("rsp_tmo", 64'(bus.rsp_tmo_o), 64'(re.tmo));
          chk("rsp_latency", 64'(cyc - last_strb), 64'(re.lat));
          h_rdata = re.rdata; h_err = re.err; h_tmo = re.tmo;
        end
      end else begin
        chk("hold_rdata", 64'(bus.rsp_rdata_o), 64'(h_rdata));
        chk("hold_err", 64'(bus.rsp_err_o), 64'(h_err));
        chk("hold_tmo", 64'(bus.rsp_tmo_o), 64'(h_tmo));
      end
    end
  end

  // Target model: optional bogus ack during the strobe, then ack dly cycles into WAIT
  initial begin
    beh_t        b;
    logic        w;
    logic [31:0] a;
    bus.sys_ack = 1'b0; bus.sys_err = 1'b0; bus.sys_rdata = '0;
    forever begin
      @(negedge clk_i);
      if (rstn_i && (bus.sys_wen || bus.sys_ren)) begin
        resp_busy = 1'b1;
        if (beh_q.size() != 0) b = beh_q.pop_front();
        else b = '{0, 1'b0, 1'b0, 1'b0};
        w = bus.sys_wen;
        a = bus.sys_addr;
        if (w) mem[a] = bus.sys_wdata;
        if (b.strb_ack) begin
          bus.sys_ack = 1'b1; bus.sys_err = 1'b1; bus.sys_rdata = 32'h0BAD_F00D;
        end
        @(negedge clk_i);
        bus.sys_ack = 1'b0; bus.sys_err = 1'b0; bus.sys_rdata = '0;
        if (!b.never) begin
          repeat (b.dly) @(negedge clk_i);
          bus.sys_ack   = 1'b1;
          bus.sys_err   = b.err;
          bus.sys_rdata = w ? 32'h5A5A_5A5A : (mem.exists(a) ? mem[a] : 32'hDEAD_BEEF);
          @(negedge clk_i);
          bus.sys_ack = 1'b0; bus.sys_err = 1'b0; bus.sys_rdata = '0;
        end
        resp_busy = 1'b0;
      end
    end
  end

  task automatic issue(input vec_t v, input bit keep_valid, input bit want_rsp);
    rsp_exp_t r;
    int       n;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = v.we;
    bus.cmd_addr_i  = v.addr;
    bus.cmd_wdata_i = v.wdata;
    bus.cmd_sel_i   = v.sel;
    strb_q.push_back('{v.we, v.addr, v.wdata, v.sel});
    beh_q.push_back('{v.dly, v.err, v.strb_ack, v.never});
    if (TMO_EN && (v.never || v.dly >= TB_TMO)) r = '{32'h0, 1'b1, 1'b1, TB_TMO + 1};
    else r = '{v.exp_rdata, v.exp_err, 1'b0, v.dly + 2};
    if (want_rsp) rsp_q.push_back(r);
    n = 0;
    while (!bus.cmd_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus.cmd_ready_o) begin
      fail("cmd_accept_timeout");
      bus.cmd_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    if (!keep_valid) bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((resp_busy || rsp_q.size() != 0 || strb_q.size() != 0) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) fail("drain_timeout");
    @(negedge clk_i);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
    chk("rst_sys_wen", 64'(bus.sys_wen), 64'd0);
    chk("rst_sys_ren", 64'(bus.sys_ren), 64'd0);
    chk("rst_sys_addr", 64'(bus.sys_addr), 64'd0);
    chk("rst_sys_wdata", 64'(bus.sys_wdata), 64'd0);
    chk("rst_sys_sel", 64'(bus.sys_sel), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err_o), 64'd0);
    chk("rst_rsp_tmo", 64'(bus.rsp_tmo_o), 64'd0);
  endtask

  vec_t dir[$];
  vec_t b2b[$];

  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0;
    bus.cmd_addr_i = '0; bus.cmd_wdata_i = '0; bus.cmd_sel_i = '0;

    //             we  addr    wdata        sel     dly err sa nv           exp_rdata     exp_err
    dir.push_back(mk(1, 32'h10, 32'd7000,     4'hF,    0, 0, 0, 0,          32'h0,        1'b0));
    dir.push_back(mk(0, 32'h10, 32'h0,        4'hF,    0, 0, 0, 0,          32'd7000,     1'b0));
    dir.push_back(mk(0, 32'h20, 32'h0,        4'hF,    0, 0, 1, 0,          32'hDEADBEEF, 1'b0));
    dir.push_back(mk(0, 32'h24, 32'h0,        4'hF,    1, 0, 0, 0,          32'hDEADBEEF, 1'b0));
    dir.push_back(mk(0, 32'h28, 32'h0,        4'hF,   10, 0, 0, 0,          32'hDEADBEEF, 1'b0));
    dir.push_back(mk(0, 32'h2C, 32'h0,        4'hF,    7, 0, 0, 0,          32'hDEADBEEF, 1'b0));
    dir.push_back(mk(0, 32'h30, 32'h0,        4'hF,    2, 1, 0, 0,          32'hDEADBEEF, 1'b1));
    dir.push_back(mk(1, 32'h34, 32'h1234,     4'h3,    0, 1, 0, 0,          32'h0,        1'b1));
    dir.push_back(mk(0, 32'h38, 32'h0,        4'hF,   40, 0, 0, TMO_EN,     32'hDEADBEEF, 1'b0));

    b2b.push_back(mk(1, 32'h40, 32'h11,       4'hF,    0, 0, 0, 0,          32'h0,        1'b0));
    b2b.push_back(mk(0, 32'h40, 32'h0,        4'hF,    0, 0, 0, 0,          32'h11,       1'b0));
    b2b.push_back(mk(1, 32'h44, 32'h22,       4'h1,    0, 0, 0, 0,          32'h0,        1'b0));
    b2b.push_back(mk(0, 32'h44, 32'h0,        4'hF,    0, 0, 0, 0,          32'h22,       1'b0));

    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_reset_outputs();
    rstn_i = 1'b1;
    #1;
    chk("ready_after_reset", 64'(bus.cmd_ready_o), 64'd1);
    @(negedge clk_i);

    foreach (dir[i]) begin
      issue(dir[i], 1'b0, 1'b1);
      wait_idle();
    end

    foreach (b2b[i]) issue(b2b[i], (i < 3), 1'b1);
    wait_idle();

    // Reset while waiting for ack: the late ack must not produce a response
    issue(mk(0, 32'h50, 32'h0, 4'hF, 5, 0, 0, 0, 32'hDEADBEEF, 1'b0), 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b0;
    @(negedge clk_i);
    chk_reset_outputs();
    rstn_i = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk_i);
    issue(mk(0, 32'h10, 32'h0, 4'hF, 0, 0, 0, 0, 32'd7000, 1'b0), 1'b0, 1'b1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sys_bus_initiator.md
SYS_BUS_INITIATOR -- requirements
Module: sys_bus_initiator

Interface
REQ-001 SHALL have parameter AW, default 32, sys bus address width.
REQ-002 SHALL have parameter DW, default 32, sys bus data width.
REQ-003 SHALL have parameter TMO, default 255, ack timeout in clk_i cycles, range 1..65535.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic rises on it.
REQ-005 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid_i  in  1  command offered.
REQ-007 SHALL have port cmd_ready_o  out  1  command accepted when valid&ready.
REQ-008 SHALL have port cmd_we_i  in  1  1=write, 0=read.
REQ-009 SHALL have ports cmd_addr_i  in  AW  and  cmd_wdata_i  in  DW  for target address and write data.
REQ-010 SHALL have port cmd_sel_i  in  DW/8  byte select.
REQ-011 SHALL have port rsp_valid_o  out  1  response pulse, 1 cycle.
REQ-012 SHALL have ports rsp_rdata_o  out  DW  read data, rsp_err_o  out  1  slave error, rsp_tmo_o  out  1  timeout flag.
REQ-013 SHALL have ports sys_addr  out  AW,  sys_wdata  out  DW,  sys_sel  out  DW/8,  sys_wen  out  1,  sys_ren  out  1.
REQ-014 SHALL have ports sys_rdata  in  DW,  sys_err  in  1,  sys_ack  in  1.

Function
REQ-015 SHALL implement FSM IDLE -> STRB -> WAIT -> RSP -> IDLE.
REQ-016 In IDLE, cmd_ready_o SHALL be 1; it SHALL be 0 in every other state.
REQ-017 On cmd_valid_i&cmd_ready_o, the block SHALL register addr/wdata/sel/we and go to STRB.
REQ-018 In STRB, sys_wen (we=1) or sys_ren (we=0) SHALL be high for exactly one cycle, with sys_addr/sys_wdata/sys_sel valid; then go to WAIT.
REQ-019 sys_addr/sys_wdata/sys_sel SHALL hold their values from STRB until the next accepted command.
REQ-020 sys_ack SHALL be ignored in IDLE and STRB; in WAIT, the first cycle with sys_ack=1 SHALL capture sys_rdata (reads only; writes leave rsp_rdata_o at 0) and sys_err, then go to RSP.
REQ-021 In RSP, rsp_valid_o SHALL be 1 for one cycle with the captured rsp_rdata_o/rsp_err_o; then go to IDLE.
REQ-022 Minimum latency SHALL be: accept at cycle N, strobe at N+1, ack at N+2 earliest, rsp_valid_o at N+3; a new command SHALL be accepted at N+4 earliest.
REQ-023 No back-pressure on the response SHALL exist; the consumer SHALL take rsp_valid_o when pulsed.
REQ-024 sys_wen and sys_ren SHALL never be high in the same cycle.
REQ-025 rsp_rdata_o, rsp_err_o and rsp_tmo_o SHALL hold their values until the next rsp_valid_o.

Reset
REQ-026 While rstn_i=0: state=IDLE; cmd_ready_o=0; sys_wen=sys_ren=0; sys_addr, sys_wdata, sys_sel, rsp_* =0; timeout counter=0.
REQ-027 cmd_ready_o SHALL first be 1 in the first cycle after rstn_i deasserts.
REQ-028 Reset mid-transaction SHALL abort it silently: no rsp_valid_o, and no late sys_ack is honoured.

Configuration
REQ-029 With SYS_BUS_INITIATOR_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entering WAIT and increment each WAIT cycle without ack.
REQ-030 With the macro defined: when the count reaches TMO, the block SHALL go to RSP with rsp_tmo_o=1, rsp_err_o=1 and rsp_rdata_o=0.
REQ-031 With the macro defined: an ack in the same cycle the count reaches TMO SHALL win (normal response, rsp_tmo_o=0).
REQ-032 Without the macro: WAIT SHALL last until sys_ack, no counter SHALL exist, and rsp_tmo_o SHALL be tied 0.

Structure
REQ-033 Package sys_bus_pkg SHALL hold the FSM state enum (IDLE, STRB, WAIT, RSP) and the default AW/DW constants.
REQ-034 The block SHALL contain no sub-module; the FSM and counter are inline.

Verification
REQ-035 Write 0x10=7000 to red_pitaya_pid via this block -> one-cycle sys_wen with sys_addr=0x10 and sys_wdata=7000; rsp_valid_o with rsp_err_o=0; read-back of 0x10 returns 7000.
REQ-036 Back-to-back cmd_valid_i held high for 4 commands -> exactly 4 strobes, each spaced >=4 cycles apart, and 4 responses in order.
REQ-037 Responder model acking 0, 1 and 10 cycles after the strobe -> rdata 0xDEADBEEF captured each time; an ack during STRB is ignored.
REQ-038 TIMEOUT_EN defined, TMO=8, responder never acks -> rsp_valid_o exactly 9 cycles after the strobe with rsp_tmo_o=1 and rsp_err_o=1.
REQ-039 Responder returns sys_err=1 with ack -> rsp_err_o=1 and rsp_tmo_o=0.
REQ-040 rstn_i pulsed low during WAIT, then ack arrives -> no rsp_valid_o; next command is served normally.
